cv32e40s_alert_agg: RTL and testbench



---
 rtl/cv32e40s_pkg.sv | 9 +
 rtl/cv32e40s_alert_esc_counter.sv | 79 +++++++
 rtl/cv32e40s_alert_agg.sv | 72 +++++++
 tb/tb_cv32e40s_alert_agg.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the cv32e40s alert path.
package cv32e40s_pkg;

  typedef enum logic {
    ESC_IDLE   = 1'b0,
    ESC_WINDOW = 1'b1
  } alert_esc_state_e;

endpackage

// File: rtl/cv32e40s_alert_esc_counter.sv
// Windowed minor-event counter: pulses when ESC_THRESHOLD events land inside
// one ESC_WINDOW-cycle window (window opens on the first event).
module cv32e40s_alert_esc_counter #(
  parameter int unsigned ESC_THRESHOLD = 4,
  parameter int unsigned ESC_WINDOW    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 event_i,
  output logic                                 esc_pulse_o,
  output logic [$clog2(ESC_THRESHOLD+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(ESC_THRESHOLD + 1);
  localparam int unsigned TMR_W = $clog2(ESC_WINDOW);
  localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(ESC_THRESHOLD);
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(ESC_WINDOW - 1);

  cv32e40s_pkg::alert_esc_state_e state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [TMR_W-1:0] timer_dec;
  logic             esc_hit;

  // The window closes when the decremented timer reaches zero, so the opening
  // cycle plus ESC_WINDOW-1 further cycles form the window.
  assign timer_dec = timer_reg - TMR_W'(1);
  assign esc_hit   = (state_reg == cv32e40s_pkg::ESC_WINDOW) && event_i &&
                     ((count_reg + CNT_W'(1)) == CNT_THR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= cv32e40s_pkg::ESC_IDLE;
      count_reg <= '0;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    timer_next = timer_reg;
    case (state_reg)
      cv32e40s_pkg::ESC_IDLE: begin
        if (event_i) begin
          state_next = cv32e40s_pkg::ESC_WINDOW;
          count_next = CNT_W'(1);
          timer_next = TMR_INIT;
        end
      end
      cv32e40s_pkg::ESC_WINDOW: begin
        timer_next = timer_dec;
        if (esc_hit || (timer_dec == '0)) begin
          state_next = cv32e40s_pkg::ESC_IDLE;
          count_next = '0;
          timer_next = '0;
        end else if (event_i) begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = cv32e40s_pkg::ESC_IDLE;
        count_next = '0;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin
    esc_pulse_o = esc_hit;
  end

  assign count_o = count_reg;

endmodule

// File: rtl/cv32e40s_alert_agg.sv
// Alert aggregator: registered minor/major alerts, sticky cause capture and
// escalation of bursts of minor events into a major alert.
module cv32e40s_alert_agg #(
  parameter int unsigned NUM_MINOR     = 2,
  parameter int unsigned NUM_MAJOR     = 5,
  parameter int unsigned ESC_THRESHOLD = 4,
  parameter int unsigned ESC_WINDOW    = 16,
  parameter bit          STICKY_MAJOR  = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_MINOR-1:0]                minor_i,
  input  logic [NUM_MAJOR-1:0]                major_i,
  input  logic                                clr_i,
  output logic                                alert_minor_o,
  output logic                                alert_major_o,
  output logic [NUM_MINOR-1:0]                minor_cause_o,
  output logic [NUM_MAJOR:0]                  major_cause_o,
  output logic [$clog2(ESC_THRESHOLD+1)-1:0]  esc_count_o
);

  if (!((ESC_WINDOW >= ESC_THRESHOLD) && (ESC_THRESHOLD >= 2) &&
        (NUM_MINOR >= 1) && (NUM_MAJOR >= 1))) begin : g_param_check
    $error("cv32e40s_alert_agg: need ESC_WINDOW >= ESC_THRESHOLD >= 2 and at least one source of each kind");
  end

  logic             minor_event;
  logic             esc_pulse;
  logic             major_cond;
  logic [NUM_MAJOR:0] major_set;

  assign minor_event = |minor_i;
  assign major_cond  = (|major_i) | esc_pulse;
  assign major_set   = {esc_pulse, major_i};

  cv32e40s_alert_esc_counter #(
    .ESC_THRESHOLD (ESC_THRESHOLD),
    .ESC_WINDOW    (ESC_WINDOW)
  ) u_esc_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .event_i     (minor_event),
    .esc_pulse_o (esc_pulse),
    .count_o     (esc_count_o)
  );

  // Cause bits: a source high in the clear cycle keeps its bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_minor_o <= 1'b0;
      minor_cause_o <= '0;
      major_cause_o <= '0;
    end else begin
      alert_minor_o <= minor_event;
      minor_cause_o <= (clr_i ? '0 : minor_cause_o) | minor_i;
      major_cause_o <= (clr_i ? '0 : major_cause_o) | major_set;
    end
  end

  if (STICKY_MAJOR) begin : g_major_sticky
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alert_major_o <= 1'b0;
      else        alert_major_o <= alert_major_o | major_cond;
    end
  end else begin : g_major_follow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alert_major_o <= 1'b0;
      else        alert_major_o <= major_cond;
    end
  end

endmodule

// File: tb/tb_cv32e40s_alert_agg.sv
// Bench for cv32e40s_alert_agg: directed scenarios plus randomized traffic
// checked against a window/timestamp model, on a non-sticky and a sticky DUT.
module tb_cv32e40s_alert_agg;

  localparam int THR = 3;
  localparam int WIN = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] minor_i = '0;
  logic [3:0] major_i = '0;
  logic       clr_i = 1'b0;

  logic       alert_minor_o, alert_major_o;
  logic [1:0] minor_cause_o;
  logic [4:0] major_cause_o;
  logic [1:0] esc_count_o;
  logic       s_alert_minor_o, s_alert_major_o;
  logic [1:0] s_minor_cause_o;
  logic [4:0] s_major_cause_o;
  logic [1:0] s_esc_count_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: window as a start timestamp plus an event count.
  int         m_cyc, m_start, m_cnt;
  bit         m_open;
  logic       exp_minor, exp_major, exp_major_s;
  logic [1:0] exp_minor_cause;
  logic [4:0] exp_major_cause;

  logic [10:0] dut_vec, sdut_vec, exp_vec, exp_svec;
  assign dut_vec  = {alert_minor_o, alert_major_o, minor_cause_o, major_cause_o, esc_count_o};
  assign sdut_vec = {s_alert_minor_o, s_alert_major_o, s_minor_cause_o, s_major_cause_o, s_esc_count_o};
  assign exp_vec  = {exp_minor, exp_major, exp_minor_cause, exp_major_cause, 2'(m_cnt)};
  assign exp_svec = {exp_minor, exp_major_s, exp_minor_cause, exp_major_cause, 2'(m_cnt)};

  always #5 clk = ~clk;

  cv32e40s_alert_agg #(
    .NUM_MINOR(2), .NUM_MAJOR(4), .ESC_THRESHOLD(THR), .ESC_WINDOW(WIN), .STICKY_MAJOR(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .minor_i(minor_i), .major_i(major_i), .clr_i(clr_i),
    .alert_minor_o(alert_minor_o), .alert_major_o(alert_major_o),
    .minor_cause_o(minor_cause_o), .major_cause_o(major_cause_o), .esc_count_o(esc_count_o)
  );

  cv32e40s_alert_agg #(
    .NUM_MINOR(2), .NUM_MAJOR(4), .ESC_THRESHOLD(THR), .ESC_WINDOW(WIN), .STICKY_MAJOR(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .minor_i(minor_i), .major_i(major_i), .clr_i(clr_i),
    .alert_minor_o(s_alert_minor_o), .alert_major_o(s_alert_major_o),
    .minor_cause_o(s_minor_cause_o), .major_cause_o(s_major_cause_o), .esc_count_o(s_esc_count_o)
  );

  task automatic model_reset();
    m_cyc = 0; m_start = 0; m_cnt = 0; m_open = 1'b0;
    exp_minor = 1'b0; exp_major = 1'b0; exp_major_s = 1'b0;
    exp_minor_cause = '0; exp_major_cause = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; minor_i = '0; major_i = '0; clr_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, return #1 after it.
  task automatic drive(input logic [1:0] mi, input logic [3:0] ma, input logic c);
    logic esc;
    minor_i = mi; major_i = ma; clr_i = c;
    @(posedge clk);
    esc = 1'b0;
    if (mi != 2'b00) begin
      if (!m_open) begin
        m_open = 1'b1; m_start = m_cyc; m_cnt = 1;
      end else begin
        m_cnt++;
        if (m_cnt == THR) begin esc = 1'b1; m_open = 1'b0; m_cnt = 0; end
      end
    end
    if (m_open && (m_cyc - m_start == WIN - 1)) begin m_open = 1'b0; m_cnt = 0; end
    exp_minor       = |mi;
    exp_major       = (|ma) | esc;
    exp_major_s     = exp_major_s | exp_major;
    exp_minor_cause = (c ? 2'b00 : exp_minor_cause) | mi;
    exp_major_cause = (c ? 5'b00000 : exp_major_cause) | {esc, ma};
    m_cyc++;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 11'd0 || sdut_vec !== 11'd0) begin
      errors++;
      $display("FAIL reset_async: got %b / %b, want all zero", dut_vec, sdut_vec);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (dut_vec !== 11'd0 || sdut_vec !== 11'd0) begin
      errors++;
      $display("FAIL reset_release: got %b / %b, want all zero", dut_vec, sdut_vec);
    end
    $display("test_reset done");
  endtask

  task automatic test_major_pulse();
    do_reset();
    repeat (5) drive(2'b00, 4'b0000, 1'b0);
    drive(2'b00, 4'b0100, 1'b0);
    checks++;
    if (alert_major_o !== 1'b1 || major_cause_o !== 5'b00100) begin
      errors++;
      $display("FAIL major_pulse_c6: major=%b cause=%b, want 1 00100", alert_major_o, major_cause_o);
    end
    drive(2'b00, 4'b0000, 1'b0);
    checks++;
    if (alert_major_o !== 1'b0 || major_cause_o !== 5'b00100) begin
      errors++;
      $display("FAIL major_pulse_c7: major=%b cause=%b, want 0 00100", alert_major_o, major_cause_o);
    end
    repeat (3) drive(2'b00, 4'b0000, 1'b0);
    drive(2'b00, 4'b0000, 1'b1);
    checks++;
    if (major_cause_o !== 5'b00000 || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL major_clear_c11: cause=%b vec=%b, want 00000 vec=%b", major_cause_o, dut_vec, exp_vec);
    end
    $display("test_major_pulse done");
  endtask

  task automatic test_escalation();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive((c == 0 || c == 3 || c == 7) ? 2'($urandom_range(1, 3)) : 2'b00, 4'b0000, 1'b0);
      if (c == 3) begin
        checks++;
        if (esc_count_o !== 2'd2) begin
          errors++;
          $display("FAIL esc_count_c4: got %0d, want 2", esc_count_o);
        end
      end
    end
    checks++;
    if (alert_major_o !== 1'b1 || major_cause_o[4] !== 1'b1 || esc_count_o !== 2'd0 || alert_minor_o !== 1'b1) begin
      errors++;
      $display("FAIL escalation_c8: major=%b cause=%b count=%0d minor=%b, want 1 1xxxx 0 1",
               alert_major_o, major_cause_o, esc_count_o, alert_minor_o);
    end
    $display("test_escalation done");
  endtask

  task automatic test_window_expiry();
    bit saw_major;
    saw_major = 1'b0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive((c == 0 || c == 3 || c == 8) ? 2'b01 : 2'b00, 4'b0000, 1'b0);
      saw_major = saw_major | (alert_major_o === 1'b1);
      if (c == 7) begin
        checks++;
        if (esc_count_o !== 2'd0) begin
          errors++;
          $display("FAIL window_closed_c8: count=%0d, want 0", esc_count_o);
        end
      end
    end
    checks++;
    if (saw_major || esc_count_o !== 2'd1 || major_cause_o[4] !== 1'b0) begin
      errors++;
      $display("FAIL window_expiry_c9: saw_major=%0d count=%0d cause=%b, want 0 1 0xxxx",
               saw_major, esc_count_o, major_cause_o);
    end
    $display("test_window_expiry done");
  endtask

  task automatic test_per_cycle();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 4'b0000, 1'b0);
      checks++;
      if (alert_minor_o !== 1'b1 || alert_major_o !== (c == 2)) begin
        errors++;
        $display("FAIL per_cycle_c%0d: minor=%b major=%b, want 1 %0d", c + 1, alert_minor_o, alert_major_o, c == 2);
      end
    end
    checks++;
    if (minor_cause_o !== 2'b11 || major_cause_o !== 5'b10000) begin
      errors++;
      $display("FAIL per_cycle_cause: minor=%b major=%b, want 11 10000", minor_cause_o, major_cause_o);
    end
    drive(2'b00, 4'b0000, 1'b0);
    checks++;
    if (alert_minor_o !== 1'b0 || alert_major_o !== 1'b0 || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL per_cycle_c4: vec=%b, want %b", dut_vec, exp_vec);
    end
    $display("test_per_cycle done");
  endtask

  task automatic test_clear_collision();
    do_reset();
    drive(2'b01, 4'b1000, 1'b0);
    repeat (3) drive(2'b00, 4'b0000, 1'b0);
    drive(2'b00, 4'b0001, 1'b1);
    checks++;
    if (major_cause_o !== 5'b00001 || minor_cause_o !== 2'b00) begin
      errors++;
      $display("FAIL clear_collision_c5: major=%b minor=%b, want 00001 00", major_cause_o, minor_cause_o);
    end
    $display("test_clear_collision done");
  endtask

  task automatic test_sticky();
    do_reset();
    repeat (2) drive(2'b00, 4'b0000, 1'b0);
    drive(2'b00, 4'b0010, 1'b0);
    drive(2'b00, 4'b0000, 1'b0);
    checks++;
    if (s_alert_major_o !== 1'b1 || alert_major_o !== 1'b0) begin
      errors++;
      $display("FAIL sticky_hold: sticky=%b plain=%b, want 1 0", s_alert_major_o, alert_major_o);
    end
    drive(2'b00, 4'b0000, 1'b1);
    drive(2'b01, 4'b0000, 1'b0);
    drive(2'b10, 4'b0000, 1'b0);
    checks++;
    if (s_alert_major_o !== 1'b1 || s_major_cause_o !== 5'b00000 || s_esc_count_o !== 2'd2) begin
      errors++;
      $display("FAIL sticky_after_clr: major=%b cause=%b count=%0d, want 1 00000 2",
               s_alert_major_o, s_major_cause_o, s_esc_count_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_alert_major_o !== 1'b0 || s_esc_count_o !== 2'd0 || s_minor_cause_o !== 2'b00) begin
      errors++;
      $display("FAIL sticky_async_reset: major=%b count=%0d cause=%b, want 0 0 00",
               s_alert_major_o, s_esc_count_o, s_minor_cause_o);
    end
    do_reset();
    $display("test_sticky done");
  endtask

  task automatic test_random();
    logic [1:0] mi;
    logic [3:0] ma;
    logic       c;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      mi = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ma = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      c  = ($urandom_range(0, 15) == 0);
      drive(mi, ma, c);
      checks++;
      if (dut_vec !== exp_vec || sdut_vec !== exp_svec) begin
        errors++;
        $display("FAIL random_c%0d: got %b / %b, want %b / %b", n, dut_vec, sdut_vec, exp_vec, exp_svec);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_major_pulse();
    test_escalation();
    test_window_expiry();
    test_per_cycle();
    test_clear_collision();
    test_sticky();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
